// File: rtl/spi_pkg.sv
// Shared state type and constants for the SPI master transfer sequencer.
package spi_pkg;

    localparam int SPI_DIV_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        SETUP,
        XFER,
        HOLD,
        DONE
    } spi_ctrl_state_e;

endpackage

// File: rtl/spi_master_shifter.sv
// TX/RX shift registers for an MSB-first SPI transfer.
// The transmit word is left-aligned on load so the MSB is always the next bit out.
module spi_master_shifter #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              load,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [LEN_W-1:0]  load_len,
    input  logic              mosi_load,
    input  logic              shift_tx,
    input  logic              shift_rx,
    input  logic              miso,
    output logic              mosi,
    output logic [DATA_W-1:0] rx_shift
);

    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic              mosi_q, mosi_d;

    always_comb begin
        tx_d   = tx_q;
        rx_d   = rx_q;
        mosi_d = mosi_q;
        if (load) begin
            tx_d = tx_data << (LEN_W'(DATA_W) - load_len);
            rx_d = '0;
        end else begin
            // mosi is a register so it only moves on SETUP entry or a counted fall.
            if (mosi_load) begin
                mosi_d = tx_q[DATA_W-1];
            end
            if (shift_tx) begin
                tx_d   = tx_q << 1;
                mosi_d = tx_q[DATA_W-2];
            end
            if (shift_rx) begin
                rx_d = {rx_q[DATA_W-2:0], miso};
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_q   <= '0;
            rx_q   <= '0;
            mosi_q <= 1'b0;
        end else begin
            tx_q   <= tx_d;
            rx_q   <= rx_d;
            mosi_q <= mosi_d;
        end
    end

    assign mosi     = mosi_q;
    assign rx_shift = rx_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// Transfer sequencer for one SPI mode-0 master channel: frames cs_n, programs and
// enables the clock generator, and steps the shifter on its rise/fall pulses.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int LEN_W    = $clog2(DATA_W) + 1,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 abort,
    input  logic [DATA_W-1:0]    tx_data,
    input  logic [LEN_W-1:0]     bit_len,
    input  logic [SPI_DIV_W-1:0] div_cfg,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_W-1:0]    rx_data,
    output logic                 cs_n,
    output logic                 mosi,
    input  logic                 miso,
    output logic                 clk_en,
    output logic [SPI_DIV_W-1:0] clk_div,
    output logic                 clk_div_valid,
    input  logic                 spi_rise,
    input  logic                 spi_fall
);

    localparam int TMR_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    spi_ctrl_state_e state_q, state_d;

    logic [LEN_W-1:0]     len_q, len_d;
    logic [LEN_W-1:0]     rise_cnt_q, rise_cnt_d;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic [SPI_DIV_W-1:0] div_q, div_d;
    logic [DATA_W-1:0]    rx_data_q, rx_data_d;

    logic [LEN_W-1:0]  n_eff;
    logic [LEN_W-1:0]  rise_seen;
    logic [DATA_W-1:0] rx_shift;
    logic              load, mosi_load, shift_tx, shift_rx, fall_ok, fall_last;
    logic              setup_end, hold_end;

    // Event decode; abort takes priority over any clkgen pulse in the same cycle.
    always_comb begin
        n_eff     = (bit_len == '0 || bit_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : bit_len;
        load      = (state_q == IDLE) && start;
        mosi_load = (state_q == CFG) && !abort;
        shift_rx  = (state_q == XFER) && spi_rise && !abort;
        fall_ok   = (state_q == XFER) && spi_fall && !abort;
        rise_seen = rise_cnt_q + {{(LEN_W-1){1'b0}}, shift_rx};
        shift_tx  = fall_ok && (rise_seen < len_q);
        fall_last = fall_ok && (rise_seen == len_q);
        setup_end = (tmr_q == TMR_W'(CS_SETUP - 1));
        hold_end  = (tmr_q == TMR_W'(CS_HOLD - 1));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = CFG;
            CFG:   state_d = abort ? HOLD : SETUP;
            SETUP: begin
                if (abort) begin
                    state_d = HOLD;
                end else if (setup_end) begin
                    state_d = XFER;
                end
            end
            XFER:  if (abort || fall_last) state_d = HOLD;
            HOLD:  if (hold_end) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        len_d      = len_q;
        div_d      = div_q;
        rise_cnt_d = rise_cnt_q;
        rx_data_d  = rx_data_q;
        tmr_d      = '0;
        if (load) begin
            len_d      = n_eff;
            div_d      = div_cfg;
            rise_cnt_d = '0;
        end
        if (shift_rx) begin
            rise_cnt_d = rise_seen;
        end
        // The timer restarts on every state change, so it counts cycles spent in SETUP/HOLD.
        if ((state_q == state_d) && (state_q == SETUP || state_q == HOLD)) begin
            tmr_d = tmr_q + 1'b1;
        end
        if (state_q == HOLD && state_d == DONE) begin
            rx_data_d = rx_shift;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            len_q      <= '0;
            div_q      <= '0;
            rise_cnt_q <= '0;
            tmr_q      <= '0;
            rx_data_q  <= '0;
        end else begin
            len_q      <= len_d;
            div_q      <= div_d;
            rise_cnt_q <= rise_cnt_d;
            tmr_q      <= tmr_d;
            rx_data_q  <= rx_data_d;
        end
    end

    always_comb begin
        busy          = (state_q == CFG) || (state_q == SETUP) || (state_q == XFER) || (state_q == HOLD);
        done          = (state_q == DONE);
        cs_n          = !((state_q == SETUP) || (state_q == XFER) || (state_q == HOLD));
        clk_en        = (state_q == XFER);
        clk_div_valid = (state_q == CFG);
        clk_div       = div_q;
        rx_data       = rx_data_q;
    end

    spi_master_shifter #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_shifter (
        .clk       (clk),
        .rstn      (rstn),
        .load      (load),
        .tx_data   (tx_data),
        .load_len  (n_eff),
        .mosi_load (mosi_load),
        .shift_tx  (shift_tx),
        .shift_rx  (shift_rx),
        .miso      (miso),
        .mosi      (mosi),
        .rx_shift  (rx_shift)
    );

endmodule
